mbist_march_ctrl: RTL and testbench
===================================

// Module: mbist_march_ctrl
// PURPOSE
//  March C- sequencer for the MBIST engine. Sits directly upstream of the address counter:
//  drives its load/direction/enable controls and uses its output q as the memory address.
//  Issues read/write ops to the memory under test and compares the read data.
//  Reports done/pass plus the first failing address and element.
//  March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 dn(r0,w1); E4 dn(r1,w0); E5 up(r0).
// PARAMETERS
//  ADDR_W  10  address width; equals counter length; DEPTH = 2**ADDR_W
//  DATA_W  8   memory word width; background 0 = all-zeros, 1 = all-ones
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse; begins a test when idle
//  cnt_q      in   ADDR_W  current address from counter (memory address)
//  cnt_din    out  ADDR_W  counter load value (0 for up elements, DEPTH-1 for down)
//  cnt_ld     out  1       counter load
//  cnt_ud     out  1       counter direction: 1 = up, 0 = down
//  cnt_en     out  1       counter enable
//  mem_cs     out  1       memory chip select
//  mem_we     out  1       1 = write, 0 = read (valid when mem_cs = 1)
//  mem_wdata  out  DATA_W  write data
//  mem_rdata  in   DATA_W  read data, valid 1 cycle after the read op
//  busy       out  1       test in progress
//  done       out  1       test finished; held until next accepted start
//  pass       out  1       valid with done: 1 = no miscompare
//  fail_addr  out  ADDR_W  address of first miscompare
//  fail_elem  out  3       element index (0-5) of first miscompare
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM in IDLE.
//  - FSM: IDLE -> SETUP -> RUN -> (SETUP | DRAIN) -> DONE -> (SETUP on start).
//  - Start acceptance: start is sampled only in IDLE or DONE and is ignored otherwise.
//    On acceptance: clear done/pass/fail regs, element = 0, go to SETUP.
//  - SETUP (1 cycle):
//    - cnt_en = 1, cnt_ld = 1, cnt_din = element start address, mem_cs = 0.
//    - Next state: RUN with op index 0.
//  - RUN (1 cycle per op):
//    - mem_cs = 1; mem_we and mem_wdata per the current element and op.
//    - Address = cnt_q.
//    - On the element's last op: cnt_en = 1, cnt_ld = 0, cnt_ud = element direction,
//      op index returns to 0. Otherwise cnt_en = 0.
//  - Last address: DEPTH-1 for up elements, 0 for down elements.
//    - Last op at the last address: no counter step (cnt_en = 0).
//    - Next state is SETUP for the next element, or DRAIN after E5.
//  - Compare pipeline:
//    - Each read registers the expected background, cnt_q and the element index.
//    - On the next cycle, mem_rdata is compared with the expected value.
//    - The first mismatch sets the sticky fail flag and captures fail_addr/fail_elem.
//      Later mismatches do not overwrite them.
//  - DRAIN (1 cycle): compares the final E5 read; no memory op.
//  - DONE: busy = 0, done = 1, pass = !fail. Outputs hold until the next accepted start.
//  - busy = 1 in SETUP, RUN and DRAIN.
//  - Latency: done rises 10*DEPTH + 7 cycles after the edge that samples start.
//  - Counter outputs never wrap, because no step is issued at the last address.
//  - rst_n asserted mid-test: asynchronously return to IDLE, all outputs to 0,
//    the pending compare is discarded.
// TESTING
//  - Reset: rst_n low mid-RUN -> busy/done/mem_cs = 0 at once; IDLE after release.
//  - Good memory, ADDR_W = 4, DATA_W = 8, start pulse -> done at cycle 167, pass = 1.
//    Op trace matches March C- (E0 writes 0x00 to addresses 0..15 ascending).
//  - Stuck-at-1 bit 0 at addr 5 -> pass = 0, fail_addr = 5, fail_elem = 1.
//  - Coupling fault detected only in E3 at addr 9 -> fail_elem = 3, fail_addr = 9.
//  - Faults at addr 2 and addr 7 -> fail_addr = 2; later miscompares do not overwrite.
//  - start re-pulsed at cycle 50 -> ignored, done still at 167.
//    start in DONE -> new run, done/pass cleared the next cycle.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- sequencer driving an external address counter and a memory under test.
// Control outputs decode the registered state; the compare runs one cycle behind each read.
module mbist_march_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cnt_q,
  output logic [ADDR_W-1:0] cnt_din,
  output logic              cnt_ld,
  output logic              cnt_ud,
  output logic              cnt_en,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);
  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [2:0] elem, rd_elem;
  logic op, run, up, single, rd_op, wr_op, last_op, last_addr, rd_bg, wr_bg, mism, fail;
  logic rd_v, rd_exp;
  logic [ADDR_W-1:0] rd_addr;
  always_comb begin
    run = state == RUN;
    up = !(elem == 3'd3 || elem == 3'd4);
    single = elem == 3'd0 || elem == 3'd5;
    rd_bg = elem == 3'd2 || elem == 3'd4;
    wr_bg = elem == 3'd1 || elem == 3'd3;
    rd_op = run && !op && elem != 3'd0;
    wr_op = run && (elem == 3'd0 || op);
    last_op = single || op;
    last_addr = up ? &cnt_q : ~|cnt_q;
    cnt_ld = state == SETUP;
    cnt_en = cnt_ld || (run && last_op && !last_addr);
    cnt_ud = cnt_en && up;
    cnt_din = {ADDR_W{cnt_ld && !up}};
    mem_cs = run;
    mem_we = wr_op;
    mem_wdata = {DATA_W{wr_op && wr_bg}};
    mism = rd_v && mem_rdata != {DATA_W{rd_exp}};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      elem <= '0;
      op <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      rd_v <= 1'b0;
      rd_exp <= 1'b0;
      rd_addr <= '0;
      rd_elem <= '0;
    end else begin
      rd_v <= rd_op;
      rd_exp <= rd_bg;
      rd_addr <= cnt_q;
      rd_elem <= elem;
      // only the first miscompare is recorded
      if (mism && !fail) begin
        fail <= 1'b1;
        fail_addr <= rd_addr;
        fail_elem <= rd_elem;
      end
      case (state)
        IDLE, DONE: if (start) begin
          state <= SETUP;
          elem <= '0;
          op <= 1'b0;
          busy <= 1'b1;
          done <= 1'b0;
          pass <= 1'b0;
          fail <= 1'b0;
          fail_addr <= '0;
          fail_elem <= '0;
        end
        SETUP: begin
          state <= RUN;
          op <= 1'b0;
        end
        RUN: begin
          op <= !last_op;
          if (last_op && last_addr) begin
            state <= elem == 3'd5 ? DRAIN : SETUP;
            elem <= elem + 3'd1;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          pass <= !(fail || mism);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: checks the March C- sequencer against a table-driven algorithm model
// with an up/down counter and a fault-injectable synchronous memory around the DUT.
module tb_mbist_march_ctrl;
  localparam int AW = 4, DW = 8, DEPTH = 16, LAT = 10 * DEPTH + 7;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW-1:0] cnt_q, cnt_din, fail_addr;
  logic cnt_ld, cnt_ud, cnt_en, mem_cs, mem_we, busy, done, pass;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0] fail_elem;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sa1 [DEPTH];
  logic [DW-1:0] sa0 [DEPTH];
  logic cf_en = 1'b0;
  logic [AW-1:0] cf_agg = '0, cf_vic = '0;
  logic [2:0] cf_bit = '0;
  logic [AW+DW:0] trace_q[$], exp_q[$];
  int vectors = 0, errors = 0, cyc = 0;

  mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cnt_q(cnt_q), .cnt_din(cnt_din),
    .cnt_ld(cnt_ld), .cnt_ud(cnt_ud), .cnt_en(cnt_en), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_ld ? cnt_din : cnt_ud ? cnt_q + 1'b1 : cnt_q - 1'b1;

  // memory with stuck-at masks on read and an up-transition coupling fault on write
  always @(posedge clk)
    if (mem_cs) begin
      if (mem_we) begin
        if (cf_en && cnt_q == cf_agg && mem_wdata[cf_bit] && !mem[cnt_q][cf_bit]) mem[cf_vic][cf_bit] <= 1'b1;
        mem[cnt_q] <= mem_wdata;
      end else mem_rdata <= (mem[cnt_q] | sa1[cnt_q]) & ~sa0[cnt_q];
    end

  always @(negedge clk)
    if (mem_cs) trace_q.push_back({mem_we, cnt_q, mem_we ? mem_wdata : 8'h00});

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
    cf_en = 1'b0;
  endtask

  task automatic ref_run(output logic ep, output logic [AW-1:0] ea, output logic [2:0] ee);
    logic [DW-1:0] m [DEPTH];
    logic [5:0] has_rd, has_wr, rbg, wbg, up;
    has_rd = 6'b111110;
    has_wr = 6'b011111;
    rbg = 6'b010100;
    wbg = 6'b001010;
    up = 6'b100111;
    ep = 1'b1;
    ea = '0;
    ee = '0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < DEPTH; i++) begin
        logic [AW-1:0] a;
        logic [DW-1:0] v, w;
        a = up[e] ? AW'(i) : AW'(DEPTH - 1 - i);
        if (has_rd[e]) begin
          v = (m[a] | sa1[a]) & ~sa0[a];
          exp_q.push_back({1'b0, a, 8'h00});
          if (ep && v != {DW{rbg[e]}}) begin
            ep = 1'b0;
            ea = a;
            ee = 3'(e);
          end
        end
        if (has_wr[e]) begin
          w = {DW{wbg[e]}};
          exp_q.push_back({1'b1, a, w});
          if (cf_en && a == cf_agg && w[cf_bit] && !m[a][cf_bit]) m[cf_vic][cf_bit] = 1'b1;
          m[a] = w;
        end
      end
  endtask

  task automatic run_test(input string name, input int repulse);
    logic ep;
    logic [AW-1:0] ea;
    logic [2:0] ee;
    int bad;
    ref_run(ep, ea, ee);
    @(negedge clk);
    start = 1'b1;
    trace_q.delete();
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < LAT + 50) begin
      if (cyc == repulse) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
    end
    vectors++;
    if (cyc !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, LAT);
    end
    vectors++;
    if ({busy, pass, fail_addr, fail_elem} !== {1'b0, ep, ea, ee}) begin
      errors++;
      $display("FAIL %s result: busy/pass/addr/elem got %b/%b/%0d/%0d want 0/%b/%0d/%0d",
               name, busy, pass, fail_addr, fail_elem, ep, ea, ee);
    end
    vectors++;
    if (trace_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s trace length: got %0d ops, want %0d", name, trace_q.size(), exp_q.size());
    end else begin
      bad = 0;
      foreach (exp_q[i]) begin
        vectors++;
        if (trace_q[i] !== exp_q[i]) begin
          errors++;
          if (bad++ < 5) $display("FAIL %s op %0d: got we/addr/data %h want %h", name, i, trace_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cnt_din, cnt_ld, cnt_ud, cnt_en, mem_cs, mem_we, mem_wdata, busy, done, pass, fail_addr, fail_elem} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got nonzero (busy=%b done=%b cs=%b en=%b)", busy, done, mem_cs, cnt_en);
    end
    @(negedge clk) rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, mem_cs} !== 3'b000) begin
      errors++;
      $display("FAIL reset mid-run: busy/done/cs got %b%b%b want 000", busy, done, mem_cs);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, mem_cs, cnt_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset idle: busy/done/cs/en got %b%b%b%b want 0000", busy, done, mem_cs, cnt_en);
    end
  endtask

  task automatic test_good();
    clear_faults();
    run_test("good", -1);
    vectors++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL good pass: got %b want 1", pass);
    end
  endtask

  task automatic test_stuck();
    clear_faults();
    sa1[5][0] = 1'b1;
    run_test("stuck", -1);
    vectors++;
    if ({pass, fail_addr, fail_elem} !== {1'b0, 4'd5, 3'd1}) begin
      errors++;
      $display("FAIL stuck fixed: pass/addr/elem got %b/%0d/%0d want 0/5/1", pass, fail_addr, fail_elem);
    end
  endtask

  task automatic test_coupling();
    clear_faults();
    cf_en = 1'b1;
    cf_agg = 4'd10;
    cf_vic = 4'd9;
    cf_bit = 3'd3;
    run_test("coupling", -1);
    vectors++;
    if ({pass, fail_addr, fail_elem} !== {1'b0, 4'd9, 3'd3}) begin
      errors++;
      $display("FAIL coupling fixed: pass/addr/elem got %b/%0d/%0d want 0/9/3", pass, fail_addr, fail_elem);
    end
  endtask

  task automatic test_multi();
    clear_faults();
    sa1[2][4] = 1'b1;
    sa1[7][1] = 1'b1;
    run_test("multi", -1);
    vectors++;
    if ({pass, fail_addr, fail_elem} !== {1'b0, 4'd2, 3'd1}) begin
      errors++;
      $display("FAIL multi first: pass/addr/elem got %b/%0d/%0d want 0/2/1", pass, fail_addr, fail_elem);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_faults();
    run_test("repulse", 50);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    vectors++;
    if ({done, pass, busy} !== 3'b001) begin
      errors++;
      $display("FAIL restart clear: done/pass/busy got %b%b%b want 001", done, pass, busy);
    end
    n = 0;
    while (!done && n < LAT + 50) begin
      @(posedge clk);
      #1 n++;
    end
    vectors++;
    if ({n, pass} !== {LAT, 1'b1}) begin
      errors++;
      $display("FAIL restart run: cycles/pass got %0d/%b want %0d/1", n, pass, LAT);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      logic [AW-1:0] a;
      logic [2:0] b;
      clear_faults();
      a = AW'($urandom_range(0, DEPTH - 1));
      b = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        1: sa1[a][b] = 1'b1;
        2: sa0[a][b] = 1'b1;
        3: begin
          cf_en = 1'b1;
          cf_agg = a;
          cf_vic = a + AW'($urandom_range(1, DEPTH - 1));
          cf_bit = b;
        end
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        a = AW'($urandom_range(0, DEPTH - 1));
        b = 3'($urandom_range(0, 7));
        sa0[a][b] = 1'b1;
      end
      run_test($sformatf("random%0d", k), -1);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck();
    test_coupling();
    test_multi();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
